frame_burst_reader: RTL and testbench
=====================================

# frame_burst_reader

Parametrised burst-read engine between the external-memory controller user interface and a video/DMA output FIFO, clocked by `mem_clk`. It generalises the frame read path: selectable base address from `NUM_BUFS` buffers, a partial final burst for lengths that are not a multiple of the burst size, and a FIFO-space threshold derived from the FIFO depth. A frame request from a consumer clock domain is synchronised, acknowledged, and turned into a sequence of burst reads that keep the FIFO topped up until the frame length is reached.

## Interface
- `MEM_DATA_BITS`, 32, memory data width (informational; no data path passes through the block)
- `ADDR_BITS`, 23, word-address width
- `BURST_BITS`, 10, width of `rd_burst_len`
- `NUM_BUFS`, 4, number of frame base addresses; power of two, 2..16
- `BURST_SIZE`, 16, maximum words per burst; must be < 2^BURST_BITS
- `FIFO_DEPTH`, 256, words in the downstream FIFO
- `FIFO_MARGIN`, 8, extra free words required before a burst is issued
- `WAIT_CYCLES`, 200, settle cycles after FIFO clear
- `mem_clk` in 1: the only clock
- `rst` in 1: synchronous, active-high reset
- `rd_burst_req` out 1: burst read request
- `rd_burst_len` out BURST_BITS: words in the current burst
- `rd_burst_addr` out ADDR_BITS: burst base word address
- `rd_burst_data_valid` in 1: read data beat valid
- `rd_burst_finish` in 1: burst complete, one-cycle pulse
- `read_req` in 1: asynchronous level request; held until `read_req_ack`
- `read_req_ack` out 1: request acknowledge
- `read_finish` out 1: one-cycle pulse when the frame completes
- `read_addr` in NUM_BUFS*ADDR_BITS: packed base addresses; slot k is `[k*ADDR_BITS +: ADDR_BITS]`
- `read_addr_index` in clog2(NUM_BUFS): base-address selector; asynchronous
- `read_len` in ADDR_BITS: frame length in words; asynchronous
- `fifo_aclr` out 1: FIFO clear
- `wrusedw` in 16: FIFO write-side used words

## Operation
- `read_req`, `read_addr_index` and `read_len` pass through synchronisers: 3 flops for `read_req` (`req_s`), 2 flops for the others.
- States:
  - IDLE: `req_s`=1 → ACK.
  - ACK: while `req_s`=1, hold `read_req_ack`=1 and `fifo_aclr`=1, latch `rd_burst_addr` from slot `read_addr_index`, latch the length, and clear `read_cnt`. On `req_s`=0, drop ack and aclr, clear `wait_cnt`, → WAIT.
  - WAIT: count up to `WAIT_CYCLES`, then → CHECK. If the latched length is 0, go to END instead.
  - CHECK: `req_s`=1 → ACK (abort). Otherwise, when `wrusedw` ≤ FIFO_DEPTH−BURST_SIZE−FIFO_MARGIN, set `rd_burst_len` = min(len−read_cnt, BURST_SIZE), set `rd_burst_req`=1, → BURST.
  - BURST: clear `rd_burst_req` on the first `rd_burst_data_valid`. On `rd_burst_finish`, add `rd_burst_len` to both `read_cnt` and `rd_burst_addr`, → BURST_END.
  - BURST_END: `req_s`=1 → ACK. Else if `read_cnt` < len → CHECK. Else → END.
  - END: `read_finish`=1 for one cycle, → IDLE.
- Arithmetic:
  - `read_cnt` and the length are ADDR_BITS wide.
  - The remaining count (len−read_cnt) is computed at ADDR_BITS width and compared before truncation to BURST_BITS.
  - Address addition wraps modulo 2^ADDR_BITS, with no error flag.
- A request during BURST is not honoured until BURST_END; the burst in flight always completes.
- `rd_burst_finish` and `rd_burst_data_valid` in the same cycle: both take effect.
- Unused state encodings → IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0.
- `read_req` rising edge to `read_req_ack`=1: 4 `mem_clk` cycles (3 sync flops plus one cycle in IDLE→ACK).
- `read_req` drop to `fifo_aclr`=0: 4 cycles.
- First `rd_burst_req` appears at least WAIT_CYCLES+2 cycles after ACK exits.
- `rd_burst_req` asserts one cycle after the CHECK decision and stays high until the first data beat.
- `rd_burst_finish` to the next `rd_burst_req`: minimum 3 cycles (BURST_END, CHECK, registered request).
- Reset asserted mid-burst: return to IDLE on the next edge and drop `rd_burst_req`. The controller is reset together with this block.

## Configuration
- `FRAME_READ_REPEAT_EN`:
  - Defined: END pulses `read_finish`, reloads `rd_burst_addr` from the latched base address, clears `read_cnt`, and goes to CHECK, so the same frame streams continuously until a new request or reset.
  - Undefined: END → IDLE, as described in Operation.

## Structure
- Shared package `frame_rd_pkg` holds:
  - the state enumeration (3-bit encoding)
  - the IDX_BITS = clog2(NUM_BUFS) function
  - the FIFO-threshold constant expression
- One sub-module: `sync_bus`, a generic N-flop, W-bit synchroniser. It is instantiated for `read_req` (3 flops, 1 bit), `read_addr_index`, and `read_len`.

## Test plan
- Frame of 64 words, index 2, slot 2 = 0x1000, `wrusedw`=0 → 4 bursts of len 16 at addresses 0x1000/0x1010/0x1020/0x1030, then `read_finish` for 1 cycle.
- `read_len`=37 → bursts of 16, 16, 5; final `rd_burst_addr` 0x20 past base; `read_cnt`=37.
- `wrusedw` held at 233 (threshold 232, with depth 256, burst 16, margin 8) → no `rd_burst_req`. Drop it to 232 → request issued on the next cycle.
- New `read_req` during the second burst → that burst completes, then ACK with `fifo_aclr`=1 and the new base latched. No further bursts at the old address.
- `read_len`=0 → after WAIT, `read_finish` with zero burst requests.
- `FRAME_READ_REPEAT_EN` with a 32-word frame → after 2 bursts, `read_finish` pulses and the address returns to base. Three consecutive frames are observed without a new request.

Source files
------------

// File: rtl/frame_burst_reader_pkg.sv
// Shared types and constant helpers for the frame burst read path.
package frame_rd_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACK       = 3'd1,
    S_WAIT      = 3'd2,
    S_CHECK     = 3'd3,
    S_BURST     = 3'd4,
    S_BURST_END = 3'd5,
    S_END       = 3'd6
  } rd_state_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Maximum FIFO fill at which a full burst plus safety margin still fits.
  function automatic int unsigned fifo_thresh(input int unsigned depth,
                                              input int unsigned burst,
                                              input int unsigned margin);
    return depth - burst - margin;
  endfunction

endpackage

// File: rtl/frame_burst_reader_if.sv
// Burst-read handshake between the frame reader and the memory controller user port.
interface frame_burst_reader_if #(
  parameter int unsigned ADDR_BITS  = 23,
  parameter int unsigned BURST_BITS = 10
) ();

  logic                  rd_burst_req;
  logic [BURST_BITS-1:0] rd_burst_len;
  logic [ADDR_BITS-1:0]  rd_burst_addr;
  logic                  rd_burst_data_valid;
  logic                  rd_burst_finish;

  modport master (
    output rd_burst_req,
    output rd_burst_len,
    output rd_burst_addr,
    input  rd_burst_data_valid,
    input  rd_burst_finish
  );

  modport slave (
    input  rd_burst_req,
    input  rd_burst_len,
    input  rd_burst_addr,
    output rd_burst_data_valid,
    output rd_burst_finish
  );

endinterface

// File: rtl/frame_burst_reader_sync_bus.sv
// Generic N-flop, W-bit synchroniser chain with synchronous reset.
module sync_bus #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/frame_burst_reader.sv
// Frame burst-read engine: turns a synchronised frame request into FIFO-paced burst reads.
// Optional FRAME_READ_REPEAT_EN restreams the latched frame continuously after each completion.
module frame_burst_reader
  import frame_rd_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned ADDR_BITS     = 23,
  parameter int unsigned BURST_BITS    = 10,
  parameter int unsigned NUM_BUFS      = 4,
  parameter int unsigned BURST_SIZE    = 16,
  parameter int unsigned FIFO_DEPTH    = 256,
  parameter int unsigned FIFO_MARGIN   = 8,
  parameter int unsigned WAIT_CYCLES   = 200
) (
  input  logic                          mem_clk,
  input  logic                          rst,
  frame_burst_reader_if.master          mem,
  input  logic                          read_req,
  output logic                          read_req_ack,
  output logic                          read_finish,
  input  logic [NUM_BUFS*ADDR_BITS-1:0] read_addr,
  input  logic [idx_bits(NUM_BUFS)-1:0] read_addr_index,
  input  logic [ADDR_BITS-1:0]          read_len,
  output logic                          fifo_aclr,
  input  logic [15:0]                   wrusedw
);

  localparam int unsigned IDXW   = idx_bits(NUM_BUFS);
  localparam int unsigned THRESH = fifo_thresh(FIFO_DEPTH, BURST_SIZE, FIFO_MARGIN);
  localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 2);

  if (MEM_DATA_BITS == 0 || NUM_BUFS < 2 || NUM_BUFS > 16 ||
      (NUM_BUFS & (NUM_BUFS - 1)) != 0 || BURST_SIZE >= (1 << BURST_BITS) ||
      FIFO_DEPTH <= BURST_SIZE + FIFO_MARGIN) begin : g_bad_cfg
    $error("frame_burst_reader: invalid parameter set");
  end

  logic                  req_s;
  logic [IDXW-1:0]       idx_s;
  logic [ADDR_BITS-1:0]  len_s;

  sync_bus #(.N(3), .W(1))         u_req_sync (.clk(mem_clk), .rst(rst), .d(read_req),        .q(req_s));
  sync_bus #(.N(2), .W(IDXW))      u_idx_sync (.clk(mem_clk), .rst(rst), .d(read_addr_index), .q(idx_s));
  sync_bus #(.N(2), .W(ADDR_BITS)) u_len_sync (.clk(mem_clk), .rst(rst), .d(read_len),        .q(len_s));

  rd_state_t             state_q, state_d;
  logic                  breq_q, breq_d;
  logic [BURST_BITS-1:0] blen_q, blen_d;
  logic [ADDR_BITS-1:0]  baddr_q, baddr_d;
  logic [ADDR_BITS-1:0]  base_q, base_d;
  logic [ADDR_BITS-1:0]  flen_q, flen_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  ack_q, aclr_q, fin_q;
  logic [ADDR_BITS-1:0]  sel_base;
  logic [ADDR_BITS-1:0]  remain;

  assign sel_base = read_addr[idx_s*ADDR_BITS +: ADDR_BITS];
  assign remain   = flen_q - cnt_q;

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      breq_q  <= 1'b0;
      blen_q  <= '0;
      baddr_q <= '0;
      base_q  <= '0;
      flen_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      aclr_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      breq_q  <= breq_d;
      blen_q  <= blen_d;
      baddr_q <= baddr_d;
      base_q  <= base_d;
      flen_q  <= flen_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      // Status outputs are registered from the next state so they track the state exactly.
      ack_q   <= (state_d == S_ACK);
      aclr_q  <= (state_d == S_ACK);
      fin_q   <= (state_d == S_END);
    end
  end

  always_comb begin
    state_d = state_q;
    breq_d  = breq_q;
    blen_d  = blen_q;
    baddr_d = baddr_q;
    base_d  = base_q;
    flen_d  = flen_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: if (req_s) state_d = S_ACK;
      S_ACK: begin
        if (req_s) begin
          baddr_d = sel_base;
          base_d  = sel_base;
          flen_d  = len_s;
          cnt_d   = '0;
        end else begin
          wait_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(WAIT_CYCLES)) state_d = (flen_q == '0) ? S_END : S_CHECK;
        else                                wait_d  = wait_q + 1'b1;
      end
      S_CHECK: begin
        if (req_s) begin
          state_d = S_ACK;
        end else if (32'(wrusedw) <= THRESH) begin
          // Remainder is compared at full address width before narrowing to the burst field.
          blen_d  = (remain < ADDR_BITS'(BURST_SIZE)) ? BURST_BITS'(remain) : BURST_BITS'(BURST_SIZE);
          breq_d  = 1'b1;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (mem.rd_burst_data_valid) breq_d = 1'b0;
        if (mem.rd_burst_finish) begin
          breq_d  = 1'b0;
          cnt_d   = cnt_q + ADDR_BITS'(blen_q);
          baddr_d = baddr_q + ADDR_BITS'(blen_q);
          state_d = S_BURST_END;
        end
      end
      S_BURST_END: begin
        if (req_s)               state_d = S_ACK;
        else if (cnt_q < flen_q) state_d = S_CHECK;
        else                     state_d = S_END;
      end
      S_END: begin
`ifdef FRAME_READ_REPEAT_EN
        baddr_d = base_q;
        cnt_d   = '0;
        state_d = S_CHECK;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.rd_burst_req  = breq_q;
  assign mem.rd_burst_len  = blen_q;
  assign mem.rd_burst_addr = baddr_q;
  assign read_req_ack      = ack_q;
  assign fifo_aclr         = aclr_q;
  assign read_finish       = fin_q;

endmodule

// File: tb/tb_frame_burst_reader.sv
// Scoreboard bench for frame_burst_reader with a simple memory-controller responder.
module tb_frame_burst_reader;

  localparam int unsigned AB = 23;
  localparam int unsigned BB = 10;
  localparam int unsigned WC = 20;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_req = 1'b0;
  logic          read_req_ack;
  logic          read_finish;
  logic [4*AB-1:0] read_addr;
  logic [1:0]    read_addr_index = '0;
  logic [AB-1:0] read_len = '0;
  logic          fifo_aclr;
  logic [15:0]   wrusedw = '0;

  frame_burst_reader_if #(.ADDR_BITS(AB), .BURST_BITS(BB)) mif ();

  frame_burst_reader #(
    .MEM_DATA_BITS(32), .ADDR_BITS(AB), .BURST_BITS(BB), .NUM_BUFS(4),
    .BURST_SIZE(16), .FIFO_DEPTH(256), .FIFO_MARGIN(8), .WAIT_CYCLES(WC)
  ) dut (
    .mem_clk(mem_clk), .rst(rst), .mem(mif),
    .read_req(read_req), .read_req_ack(read_req_ack), .read_finish(read_finish),
    .read_addr(read_addr), .read_addr_index(read_addr_index), .read_len(read_len),
    .fifo_aclr(fifo_aclr), .wrusedw(wrusedw)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [BB-1:0] len;
  } burst_t;

  burst_t exp_q[$];
  int n_total = 0;
  int n_bad = 0;
  int burst_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic push_frame(input logic [AB-1:0] base, input int unsigned len);
    logic [AB-1:0] a;
    int unsigned rem;
    int unsigned l;
    a = base;
    rem = len;
    while (rem > 0) begin
      l = (rem > 16) ? 16 : rem;
      exp_q.push_back('{addr: a, len: BB'(l)});
      a = a + AB'(l);
      rem = rem - l;
    end
  endtask

  task automatic start_req(input int unsigned idx, input int unsigned len, input bit lat);
    int n = 0;
    read_addr_index = 2'(idx);
    read_len = AB'(len);
    read_req = 1'b1;
    while (!read_req_ack && n < 60) begin tick(); n++; end
    if (lat) chk("ack_latency", n, 4);
    else     chk("ack_seen", read_req_ack, 1);
    chk("aclr_with_ack", fifo_aclr, 1);
  endtask

  task automatic drop_req();
    int n = 0;
    read_req = 1'b0;
    while (fifo_aclr && n < 60) begin tick(); n++; end
    chk("aclr_drop_latency", n, 4);
    chk("ack_dropped", read_req_ack, 0);
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (!read_finish && n < 3000) begin tick(); n++; end
    chk({tag, "_finish_seen"}, read_finish, 1);
    tick();
    chk({tag, "_finish_pulse"}, read_finish, 0);
  endtask

  // Memory-controller responder: checks each request against the scoreboard, then returns data.
  initial begin
    burst_t e;
    int unsigned blen;
    mif.rd_burst_data_valid = 1'b0;
    mif.rd_burst_finish = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (!rst && mif.rd_burst_req) begin
        burst_cnt++;
        if (exp_q.size() == 0) begin
          chk("burst_unexpected", mif.rd_burst_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("burst_addr", mif.rd_burst_addr, e.addr);
          chk("burst_len", mif.rd_burst_len, e.len);
        end
        blen = mif.rd_burst_len;
        repeat (2) @(posedge mem_clk);
        for (int i = 0; i < int'(blen); i++) begin
          #1;
          mif.rd_burst_data_valid = 1'b1;
          mif.rd_burst_finish = (i == int'(blen) - 1);
          @(posedge mem_clk);
          if (rst) break;
        end
        #1;
        mif.rd_burst_data_valid = 1'b0;
        mif.rd_burst_finish = 1'b0;
      end
    end
  end

`ifndef FRAME_READ_REPEAT_EN
  task automatic test_basic();
    int b0 = burst_cnt;
    int n = 0;
    push_frame(23'h001000, 64);
    start_req(2, 64, 1);
    drop_req();
    while (!mif.rd_burst_req && n < 300) begin tick(); n++; end
    chk("first_req_gap", (n >= int'(WC) + 2 && n < 300), 1);
    wait_finish("basic");
    chk("basic_bursts", burst_cnt - b0, 4);
    chk("basic_end_addr", mif.rd_burst_addr, 23'h001040);
    chk("basic_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_partial();
    int b0 = burst_cnt;
    push_frame(23'h000100, 37);
    start_req(0, 37, 1);
    drop_req();
    wait_finish("partial");
    chk("partial_bursts", burst_cnt - b0, 3);
    chk("partial_last_len", mif.rd_burst_len, 5);
    chk("partial_end_addr", mif.rd_burst_addr, 23'h000125);
    chk("partial_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_thresh();
    int n = 0;
    int b0 = burst_cnt;
    wrusedw = 16'd233;
    push_frame(23'h000800, 16);
    start_req(1, 16, 1);
    drop_req();
    repeat (WC + 25) begin
      tick();
      if (mif.rd_burst_req) n++;
    end
    chk("thr_hold_req", n, 0);
    chk("thr_hold_bursts", burst_cnt - b0, 0);
    wrusedw = 16'd232;
    tick();
    chk("thr_release_req", mif.rd_burst_req, 1);
    wait_finish("thr");
    wrusedw = 16'd0;
  endtask

  task automatic test_abort();
    int b0 = burst_cnt;
    int b1;
    int n = 0;
    push_frame(23'h001000, 64);
    start_req(2, 64, 1);
    drop_req();
    while (burst_cnt - b0 < 2 && n < 500) begin tick(); n++; end
    start_req(0, 16, 0);
    chk("abort_old_bursts", burst_cnt - b0, 2);
    tick();
    chk("abort_new_base", mif.rd_burst_addr, 23'h000100);
    chk("abort_aclr_held", fifo_aclr, 1);
    exp_q.delete();
    push_frame(23'h000100, 16);
    b1 = burst_cnt;
    drop_req();
    wait_finish("abort");
    chk("abort_new_bursts", burst_cnt - b1, 1);
    chk("abort_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_zero();
    int b0 = burst_cnt;
    start_req(1, 0, 1);
    drop_req();
    wait_finish("zero");
    chk("zero_bursts", burst_cnt - b0, 0);
  endtask

  task automatic test_wrap();
    int b0 = burst_cnt;
    push_frame(23'h7FFFF8, 32);
    start_req(3, 32, 1);
    drop_req();
    wait_finish("wrap");
    chk("wrap_bursts", burst_cnt - b0, 2);
    chk("wrap_end_addr", mif.rd_burst_addr, 23'h000018);
  endtask
`else
  task automatic test_repeat();
    int b0 = burst_cnt;
    int b1;
    for (int f = 0; f < 4; f++) push_frame(23'h000800, 32);
    start_req(1, 32, 1);
    drop_req();
    for (int f = 0; f < 3; f++) begin
      wait_finish($sformatf("rpt%0d", f));
      chk("rpt_addr_base", mif.rd_burst_addr, 23'h000800);
    end
    chk("rpt_bursts", burst_cnt - b0, 6);
    rst = 1'b1;
    tick();
    chk("rpt_rst_req", mif.rd_burst_req, 0);
    chk("rpt_rst_addr", mif.rd_burst_addr, 0);
    rst = 1'b0;
    exp_q.delete();
    b1 = burst_cnt;
    repeat (WC + 30) tick();
    chk("rpt_rst_quiet", burst_cnt - b1, 0);
  endtask
`endif

  task automatic test_reset_mid();
    int b0 = burst_cnt;
    int b1;
    int n = 0;
    push_frame(23'h001000, 64);
    start_req(2, 64, 1);
    drop_req();
    while (burst_cnt == b0 && n < 300) begin tick(); n++; end
    chk("rstmid_req_before", mif.rd_burst_req, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_req", mif.rd_burst_req, 0);
    chk("rstmid_len", mif.rd_burst_len, 0);
    chk("rstmid_addr", mif.rd_burst_addr, 0);
    chk("rstmid_ack", read_req_ack, 0);
    chk("rstmid_aclr", fifo_aclr, 0);
    chk("rstmid_finish", read_finish, 0);
    rst = 1'b0;
    exp_q.delete();
    b1 = burst_cnt;
    repeat (WC + 30) tick();
    chk("rstmid_idle_bursts", burst_cnt - b1, 0);
    chk("rstmid_idle_req", mif.rd_burst_req, 0);
  endtask

  initial begin
    read_addr = {23'h7FFFF8, 23'h001000, 23'h000800, 23'h000100};
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_req", mif.rd_burst_req, 0);
    chk("reset_len", mif.rd_burst_len, 0);
    chk("reset_addr", mif.rd_burst_addr, 0);
    chk("reset_ack", read_req_ack, 0);
    chk("reset_aclr", fifo_aclr, 0);
    chk("reset_finish", read_finish, 0);
    rst = 1'b0;
    tick();
`ifdef FRAME_READ_REPEAT_EN
    test_repeat();
`else
    test_basic();
    test_partial();
    test_thresh();
    test_abort();
    test_zero();
    test_wrap();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
